// File: rtl/mac_pkg.sv
// Shared MAC datapath types, widths and saturation helpers.
package mac_pkg;

  localparam int PSUM_W = 13;
  localparam int SUM_W  = 14;
  localparam int Q_W    = 8;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [Q_W-1:0]    qout_t;

  localparam psum_t SAT_MAX = 13'sd4095;
  localparam psum_t SAT_MIN = -13'sd4095 - 13'sd1;

  // Clip a 14-bit two's complement sum into 13 bits; the top two bits
  // differing is the only overflow case.
  function automatic psum_t sat14to13(input logic [SUM_W-1:0] s);
    psum_t v;
    case (s[SUM_W-1:SUM_W-2])
      2'b01:   v = SAT_MAX;
      2'b10:   v = SAT_MIN;
      default: v = s[PSUM_W-1:0];
    endcase
    return v;
  endfunction

  // Arithmetic shift then clip to the signed 8-bit output range.
  function automatic qout_t clip8(input psum_t v, input int unsigned sh);
    psum_t t;
    qout_t q;
    t = v >>> sh;
    if (t > 13'sd127)       q = 8'sd127;
    else if (t < -13'sd128) q = -8'sd128;
    else                    q = t[Q_W-1:0];
    return q;
  endfunction

endpackage

// File: rtl/psum_saturate.sv
// Combinational 14->13 bit saturation with overflow indication.
module psum_saturate
  import mac_pkg::*;
(
  input  logic [SUM_W-1:0]  i_sum,
  output logic [PSUM_W-1:0] o_sat,
  output logic              o_hit
);

  assign o_sat = sat14to13(i_sum);
  assign o_hit = i_sum[SUM_W-1] ^ i_sum[SUM_W-2];

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: holds the feedback sum across channel passes and
// emits a registered, optionally ReLU'd and quantized result per pixel.
//
// state | meaning
// IDLE  | pass_cnt == 0, pre_output == 0, waiting for the first pass
// ACCUM | pass_cnt 1..NUM_PASS-1, pre_output holds the running sum
// (the output slot is tracked separately by out_valid)
module psum_accumulator
  import mac_pkg::*;
#(
  parameter int NUM_PASS  = 3,
  parameter int RELU_EN   = 1,
  parameter int OUT_SHIFT = 5
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] sum_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [12:0] pre_output,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] result,
  output logic [7:0]  result_q,
  output logic        sat_flag,
  output logic [7:0]  pass_cnt
);

  generate
    if (NUM_PASS < 2 || NUM_PASS > 255) begin : g_bad_num_pass
      $error("psum_accumulator: NUM_PASS must be in 2..255");
    end
  endgenerate

  localparam logic [7:0] LAST_PASS = 8'(NUM_PASS - 1);

  logic [7:0]  r_pass_cnt, w_cnt_nxt;
  logic [12:0] r_pre, w_pre_nxt;
  logic        r_sticky, w_sticky_nxt;

  logic        r_out_valid;
  logic [12:0] r_result;
  logic [7:0]  r_result_q;
  logic        r_sat_flag;

  logic [12:0] w_sat;
  logic        w_hit;
  logic        w_last;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_final_load;
  logic [12:0] w_relu;
  logic [7:0]  w_q;

  psum_saturate u_sat (
    .i_sum (sum_in),
    .o_sat (w_sat),
    .o_hit (w_hit)
  );

  assign w_last       = (r_pass_cnt == LAST_PASS);
  assign w_in_ready   = w_last ? (!r_out_valid || out_ready) : 1'b1;
  assign w_accept     = in_valid && w_in_ready;
  // A flush in the same cycle wins over the final pass.
  assign w_final_load = w_accept && w_last && !flush;
  assign w_relu       = ((RELU_EN != 0) && w_sat[12]) ? '0 : w_sat;
  assign w_q          = clip8($signed(w_relu), OUT_SHIFT);

  // State register: pass counter, feedback sum and sticky saturation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass_cnt <= '0;
      r_pre      <= '0;
      r_sticky   <= 1'b0;
    end else begin
      r_pass_cnt <= w_cnt_nxt;
      r_pre      <= w_pre_nxt;
      r_sticky   <= w_sticky_nxt;
    end
  end

  // Next-state logic: advance on a non-final accept, clear on final or flush.
  always_comb begin
    w_cnt_nxt    = r_pass_cnt;
    w_pre_nxt    = r_pre;
    w_sticky_nxt = r_sticky;
    if (flush || (w_accept && w_last)) begin
      w_cnt_nxt    = '0;
      w_pre_nxt    = '0;
      w_sticky_nxt = 1'b0;
    end else if (w_accept) begin
      w_cnt_nxt    = r_pass_cnt + 8'd1;
      w_pre_nxt    = w_sat;
      w_sticky_nxt = r_sticky | w_hit;
    end
  end

  // Output logic: handshake and registered values onto the ports.
  always_comb begin
    in_ready   = w_in_ready;
    pre_output = r_pre;
    pass_cnt   = r_pass_cnt;
    out_valid  = r_out_valid;
    result     = r_result;
    result_q   = r_result_q;
    sat_flag   = r_sat_flag;
  end

  // Result slot: load on final accept (even while draining), else clear on take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_q  <= '0;
      r_sat_flag  <= 1'b0;
    end else if (w_final_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_relu;
      r_result_q  <= w_q;
      r_sat_flag  <= r_sticky | w_hit;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed and sweep bench for psum_accumulator (NUM_PASS=3, OUT_SHIFT=5),
// with one ReLU-enabled and one ReLU-disabled instance on shared stimulus.
module tb_psum_accumulator;
  import mac_pkg::*;

  logic        clk;
  logic        reset;
  logic [13:0] sum_in;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, sat_flag;
  logic [12:0] pre_output, result;
  logic [7:0]  result_q, pass_cnt;

  logic        nr_in_ready, nr_out_valid, nr_sat_flag;
  logic [12:0] nr_pre_output, nr_result;
  logic [7:0]  nr_result_q, nr_pass_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;

  psum_accumulator #(.NUM_PASS(3), .RELU_EN(1), .OUT_SHIFT(5)) u_dut (
    .clk(clk), .reset(reset), .sum_in(sum_in), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .pre_output(pre_output),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_q(result_q), .sat_flag(sat_flag), .pass_cnt(pass_cnt)
  );

  psum_accumulator #(.NUM_PASS(3), .RELU_EN(0), .OUT_SHIFT(5)) u_dut_nr (
    .clk(clk), .reset(reset), .sum_in(sum_in), .in_valid(in_valid),
    .in_ready(nr_in_ready), .flush(flush), .pre_output(nr_pre_output),
    .out_valid(nr_out_valid), .out_ready(out_ready), .result(nr_result),
    .result_q(nr_result_q), .sat_flag(nr_sat_flag), .pass_cnt(nr_pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] v);
    in_valid = 1'b1;
    sum_in   = v;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; sum_in = '0;
    tick(); tick();
    chk("rst_pre", $signed(pre_output), 0);
    chk("rst_cnt", pass_cnt, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_result", $signed(result), 0);
    chk("rst_q", $signed(result_q), 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_iready", in_ready, 1);
    reset = 1'b1;
    tick();

    // Basic three-pass pixel
    push(14'h0064);
    chk("p3_pre0", $signed(pre_output), 100);
    chk("p3_cnt0", pass_cnt, 1);
    push(14'h00C8);
    chk("p3_pre1", $signed(pre_output), 200);
    chk("p3_cnt1", pass_cnt, 2);
    push(14'h012C);
    chk("p3_ovalid", out_valid, 1);
    chk("p3_result", $signed(result), 300);
    chk("p3_q", $signed(result_q), 9);
    chk("p3_sat", sat_flag, 0);
    chk("p3_cnt", pass_cnt, 0);
    chk("p3_pre", $signed(pre_output), 0);
    tick();
    chk("p3_drain", out_valid, 0);

    // Saturation on both rails
    push(14'h1000);
    chk("sat_pre0", $signed(pre_output), 4095);
    push(14'h0010);
    chk("sat_pre1", $signed(pre_output), 16);
    push(14'h2000);
    chk("sat_result", $signed(result), 0);
    chk("sat_q", $signed(result_q), 0);
    chk("sat_flag", sat_flag, 1);
    chk("sat_nr_result", $signed(nr_result), -4096);
    chk("sat_nr_q", $signed(nr_result_q), -128);
    chk("sat_nr_flag", nr_sat_flag, 1);
    tick();

    // Small negative final sum, with and without ReLU
    push(14'h0005);
    push(14'h0005);
    push(14'h3FF6);
    chk("neg_result", $signed(result), 0);
    chk("neg_q", $signed(result_q), 0);
    chk("neg_sat", sat_flag, 0);
    chk("neg_nr_result", $signed(nr_result), -10);
    chk("neg_nr_q", $signed(nr_result_q), -1);
    tick();

    // Backpressure: only the final pass stalls
    push(14'h0020);
    push(14'h0040);
    push(14'h0060);
    chk("bp_result0", $signed(result), 96);
    chk("bp_q0", $signed(result_q), 3);
    out_ready = 1'b0;
    push(14'h000A);
    chk("bp_cnt1", pass_cnt, 1);
    push(14'h0014);
    chk("bp_cnt2", pass_cnt, 2);
    chk("bp_pre", $signed(pre_output), 20);
    chk("bp_hold_valid", out_valid, 1);
    in_valid = 1'b1;
    sum_in   = 14'h0100;
    chk("bp_iready_lo", in_ready, 0);
    tick();
    tick();
    chk("bp_stall_cnt", pass_cnt, 2);
    chk("bp_stall_result", $signed(result), 96);
    chk("bp_stall_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_iready_hi", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_b2b_valid", out_valid, 1);
    chk("bp_b2b_result", $signed(result), 256);
    chk("bp_b2b_q", $signed(result_q), 8);
    chk("bp_b2b_cnt", pass_cnt, 0);
    tick();
    chk("bp_drain", out_valid, 0);

    // Flush while a result is pending
    push(14'h0040);
    push(14'h0040);
    push(14'h0080);
    out_ready = 1'b0;
    push(14'h0011);
    chk("fl_pre_before", $signed(pre_output), 17);
    flush = 1'b1; in_valid = 1'b1; sum_in = 14'h0055;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_pre", $signed(pre_output), 0);
    chk("fl_cnt", pass_cnt, 0);
    chk("fl_result", $signed(result), 128);
    chk("fl_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("fl_drain", out_valid, 0);

    // Asynchronous reset mid-accumulation with a pending result
    push(14'h0001);
    push(14'h0002);
    push(14'h0003);
    out_ready = 1'b0;
    push(14'h0010);
    push(14'h0025);
    chk("ar_cnt_before", pass_cnt, 2);
    chk("ar_pre_before", $signed(pre_output), 37);
    #2 reset = 1'b0;
    #1;
    chk("ar_pre", $signed(pre_output), 0);
    chk("ar_cnt", pass_cnt, 0);
    chk("ar_valid", out_valid, 0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();

    // Operand sweep against the package-based reference model
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        int    a, b, full;
        psum_t m_pre, m_sat, m_r;
        logic  m_sticky, m_hit;
        logic [13:0] s14;
        a = -128 + ia * 17;
        b = -128 + ib * 17;
        m_pre = '0;
        m_sticky = 1'b0;
        for (int p = 0; p < 3; p++) begin
          full  = 9 * a * b + (p * 37 - 50) + (int'(m_pre) * 64);
          s14   = full[13:0];
          m_sat = sat14to13(s14);
          m_hit = (s14[13] != s14[12]);
          push(s14);
          if (p < 2) begin
            m_pre    = m_sat;
            m_sticky = m_sticky | m_hit;
            chk("sw_pre", $signed(pre_output), int'(m_pre));
          end else begin
            m_r = m_sat[12] ? '0 : m_sat;
            chk("sw_result", $signed(result), int'(m_r));
            chk("sw_q", $signed(result_q), int'(clip8(m_r, 5)));
            chk("sw_sat", sat_flag, int'(m_sticky | m_hit));
            chk("sw_nr_result", $signed(nr_result), int'(m_sat));
            chk("sw_nr_q", $signed(nr_result_q), int'(clip8(m_sat, 5)));
          end
        end
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
